// File: rtl/opb_register_ppc2simulink_sync.sv
// OPB slave register written by the PPC and held for FPGA user logic, with a
// one-cycle update strobe and a read-only wrapping write counter.
module opb_register_ppc2simulink_sync #(
    parameter logic [31:0] C_BASEADDR         = 32'h0100_0100,
    parameter logic [31:0] C_HIGHADDR         = 32'h0100_01FF,
    parameter int          C_OPB_AWIDTH       = 32,
    parameter int          C_OPB_DWIDTH       = 32,
    parameter              C_FAMILY           = "virtex5",
    parameter logic [31:0] C_USER_RESET_VALUE = 32'h0000_0000
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
    output logic                        Sl_xferAck,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    output logic [31:0]                 user_data_out,
    output logic                        user_update
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] dbus_q, dbus_d;
    logic [31:0] data_q, data_d;
    logic [31:0] wr_count_q, wr_count_d;
    logic        update_q, update_d;
    logic        hit_s;
    logic        sel_count_s;
    logic [31:0] wdata_s;

    // Sequential beats are treated as independent single transfers.
    logic unused_seq_s;
    assign unused_seq_s = OPB_seqAddr;
    localparam bit unused_family = (C_FAMILY != "");

    // OPB byte i (BE[i]) lands on word bits [31-8i -: 8]; DBus[0] is word bit 31.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [0:3]  be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[31-8*i -: 8] = new_w[31-8*i -: 8];
            end else begin
                res[31-8*i -: 8] = old_w[31-8*i -: 8];
            end
        end
        return res;
    endfunction

    assign wdata_s     = OPB_DBus;
    assign sel_count_s = OPB_ABus[29];
    assign hit_s       = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);

    // Next-state logic: accept only in IDLE, then one ack cycle and one dead cycle.
    always_comb begin
        state_d    = state_q;
        ack_d      = 1'b0;
        dbus_d     = 32'h0000_0000;
        update_d   = 1'b0;
        data_d     = data_q;
        wr_count_d = wr_count_q;
        case (state_q)
            ST_IDLE: begin
                if (hit_s) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    if (OPB_RNW) begin
                        dbus_d = sel_count_s ? wr_count_q : data_q;
                    end else if (!sel_count_s) begin
                        data_d     = merge_bytes(data_q, wdata_s, OPB_BE);
                        update_d   = 1'b1;
                        wr_count_d = wr_count_q + 32'd1;
                    end else begin
                        data_d = data_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK:  state_d = ST_GAP;
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset also aborts any accepted transfer.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            dbus_q     <= 32'h0000_0000;
            data_q     <= C_USER_RESET_VALUE;
            wr_count_q <= 32'h0000_0000;
            update_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            dbus_q     <= dbus_d;
            data_q     <= data_d;
            wr_count_q <= wr_count_d;
            update_q   <= update_d;
        end
    end

    assign Sl_DBus       = dbus_q;
    assign Sl_xferAck    = ack_q;
    assign Sl_errAck     = 1'b0;
    assign Sl_retry      = 1'b0;
    assign Sl_toutSup    = 1'b0;
    assign user_data_out = data_q;
    assign user_update   = update_q;

endmodule

// File: tb/tb_opb_register_ppc2simulink_sync.sv
// Self-checking bench: directed scenarios plus random OPB transfers against a
// word/counter reference model.
module tb_opb_register_ppc2simulink_sync;

    localparam logic [31:0] BASE    = 32'h0100_0100;
    localparam logic [31:0] HIGH    = 32'h0100_01FF;
    localparam logic [31:0] RST_VAL = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:31] abus;
    logic [0:3]  be;
    logic [0:31] dbus_in;
    logic        rnw, sel, seq;
    logic [0:31] sl_dbus;
    logic        ack, err_ack, retry, tout_sup;
    logic [31:0] udo;
    logic        upd;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_data;
    logic [31:0] m_count;

    always #5 clk = ~clk;

    opb_register_ppc2simulink_sync #(
        .C_USER_RESET_VALUE(RST_VAL)
    ) dut (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be),
        .OPB_DBus(dbus_in), .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
        .Sl_DBus(sl_dbus), .Sl_xferAck(ack), .Sl_errAck(err_ack), .Sl_retry(retry),
        .Sl_toutSup(tout_sup), .user_data_out(udo), .user_update(upd)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One transfer from an idle slave; checks latency, data, strobe and the dead cycle.
    task automatic xfer(input logic [31:0] addr, input logic is_rd,
                        input logic [0:3] ben, input logic [31:0] wdata);
        logic        in_win;
        logic        acked;
        int          lat;
        logic [31:0] exp_rd;
        in_win = (addr >= BASE) && (addr <= HIGH);
        exp_rd = addr[2] ? m_count : m_data;
        acked  = 1'b0;
        lat    = -1;
        @(negedge clk);
        abus = addr; rnw = is_rd; be = ben; dbus_in = wdata; sel = 1'b1;
        for (int c = 0; c < 16 && !acked; c++) begin
            @(posedge clk); #1;
            if (ack) begin
                acked = 1'b1;
                lat   = c;
            end else begin
                check_eq("idle_dbus", sl_dbus, 32'h0);
                check_eq("idle_update", {31'd0, upd}, 32'h0);
                check_eq("idle_hold", udo, m_data);
            end
        end
        sel = 1'b0;
        check_eq("ack_seen", {31'd0, acked}, {31'd0, in_win});
        if (acked) begin
            check_eq("ack_latency", lat, 32'd0);
            if (is_rd) begin
                check_eq("rd_data", sl_dbus, exp_rd);
                check_eq("rd_no_update", {31'd0, upd}, 32'h0);
            end else if (!addr[2]) begin
                for (int i = 0; i < 4; i++)
                    if (ben[i]) m_data[31-8*i -: 8] = wdata[31-8*i -: 8];
                m_count = m_count + 32'd1;
                check_eq("wr_update", {31'd0, upd}, 32'h1);
                check_eq("wr_data", udo, m_data);
                check_eq("wr_dbus_zero", sl_dbus, 32'h0);
            end else begin
                check_eq("wrcnt_no_update", {31'd0, upd}, 32'h0);
                check_eq("wrcnt_hold", udo, m_data);
            end
            @(posedge clk); #1;
            check_eq("gap_ack", {31'd0, ack}, 32'h0);
            check_eq("gap_update", {31'd0, upd}, 32'h0);
            check_eq("gap_dbus", sl_dbus, 32'h0);
            @(posedge clk);
        end
    endtask

    // Select held for n edges on a DATA read: acks recur only every third cycle.
    task automatic hold_read(input int n);
        int n_ack;
        n_ack = 0;
        @(negedge clk);
        abus = BASE; rnw = 1'b1; be = 4'b0000; sel = 1'b1;
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            check_eq("hold_ack", {31'd0, ack}, {31'd0, (c % 3) == 0});
            check_eq("hold_dbus", sl_dbus, ((c % 3) == 0) ? m_data : 32'h0);
            if (ack) n_ack++;
        end
        sel = 1'b0;
        check_eq("hold_ack_count", n_ack, (n + 2) / 3);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        logic [31:0] a;
        logic [0:3]  rb;
        rst = 1'b1; sel = 1'b0; rnw = 1'b1; abus = '0; be = '0; dbus_in = '0; seq = 1'b0;
        m_data = RST_VAL; m_count = 32'h0;

        repeat (3) @(posedge clk); #1;
        check_eq("rst_udo", udo, RST_VAL);
        check_eq("rst_ack", {31'd0, ack}, 32'h0);
        check_eq("rst_dbus", sl_dbus, 32'h0);
        check_eq("rst_update", {31'd0, upd}, 32'h0);
        check_eq("const_outs", {29'd0, err_ack, retry, tout_sup}, 32'h0);
        @(negedge clk); rst = 1'b0;
        xfer(BASE + 32'd4, 1'b1, 4'b0000, 32'h0);

        xfer(BASE, 1'b0, 4'b1111, 32'h1234_5678);
        check_eq("t2_value", udo, 32'h1234_5678);
        xfer(BASE + 32'd4, 1'b1, 4'b0000, 32'h0);

        xfer(BASE, 1'b0, 4'b0101, 32'hFFFF_FFFF);
        check_eq("t3_value", udo, 32'h12FF_56FF);
        xfer(BASE, 1'b1, 4'b0000, 32'h0);

        hold_read(3);
        hold_read(6);

        xfer(32'h0100_0200, 1'b0, 4'b1111, 32'hCAFE_F00D);
        check_eq("t5_unchanged", udo, 32'h12FF_56FF);

        // Reset arriving on the accepting edge aborts the transfer.
        @(negedge clk);
        abus = BASE; rnw = 1'b0; be = 4'b1111; dbus_in = 32'hDEAD_BEEF; sel = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        check_eq("t6_no_ack", {31'd0, ack}, 32'h0);
        check_eq("t6_udo", udo, RST_VAL);
        check_eq("t6_update", {31'd0, upd}, 32'h0);
        sel = 1'b0;
        @(negedge clk); rst = 1'b0;
        m_data = RST_VAL; m_count = 32'h0;
        xfer(BASE + 32'd4, 1'b1, 4'b0000, 32'h0);

        // Jump the counter to its last value, then let one write wrap it.
        @(negedge clk);
        force dut.wr_count_q = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.wr_count_q;
        m_count = 32'hFFFF_FFFF;
        xfer(BASE, 1'b0, 4'b1000, 32'h7700_0000);
        xfer(BASE + 32'd4, 1'b1, 4'b0000, 32'h0);
        check_eq("wrap_model", m_count, 32'h0);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'h0100_0200 + 32'($urandom_range(0, 63)) * 32'd4;
                1:       a = 32'h0100_0000 + 32'($urandom_range(0, 63)) * 32'd4;
                default: a = BASE + 32'($urandom_range(0, 63)) * 32'd4;
            endcase
            rb = 4'($urandom_range(0, 15));
            xfer(a, 1'($urandom_range(0, 1)), rb, $urandom);
        end
        xfer(BASE, 1'b1, 4'b0000, 32'h0);
        xfer(BASE + 32'd4, 1'b1, 4'b0000, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
